shift_sequencer: RTL and testbench

Command-driven controller for the 4-bit load/rotate/arithmetic-shift register.
- Accepts one command at a time over a valid/ready handshake and drives the register's ParallelLoadn, RotateRight, ASRight, Data_IN and reset lines.
- Monitors the register's Q for hold and result reporting.
- The register shifts on every clock unless it is parallel-loaded, so this block holds its contents by reloading Q when it is idle.

---
 rtl/shift_seq_pkg.sv | 24 ++
 rtl/shift_sequencer_if.sv | 16 +
 rtl/step_counter.sv | 21 ++
 rtl/shift_sequencer.sv | 105 ++++++++++
 tb/tb_shift_sequencer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and defaults for the shift-register command sequencer.
package shift_seq_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 3;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_ROTL = 2'd1,
    OP_ROTR = 2'd2,
    OP_ASR  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_e;

  function automatic logic is_shift(op_e op);
    return op != OP_LOAD;
  endfunction
endpackage

// File: rtl/shift_sequencer_if.sv
// Command channel of the shift sequencer: valid/ready with op, load data and step count.
interface shift_sequencer_if
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic             cmd_valid;
  logic             cmd_ready;
  op_e              cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;

  modport master (output cmd_valid, cmd_op, cmd_data, cmd_count, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_data, cmd_count, output cmd_ready);
endinterface

// File: rtl/step_counter.sv
// Remaining-step down-counter; is_one marks the last shift step.
module step_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             is_one
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec)  cnt <= cnt - 1'b1;
  end

  assign is_one = (cnt == CNT_W'(1));
endmodule

// File: rtl/shift_sequencer.sv
// Command-driven controller for a 4-bit load/rotate/arithmetic-shift register.
// The register shifts every clock unless loaded, so idle states reload Q to hold it.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clock,
  input  logic               resetn,
  shift_sequencer_if.slave   cmd,
  input  logic [WIDTH-1:0]   Q_fb,
  output logic               ParallelLoadn,
  output logic               RotateRight,
  output logic               ASRight,
  output logic [WIDTH-1:0]   Data_IN,
  output logic               reg_reset,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);
  state_e           state, state_nxt;
  op_e              op_q;
  logic [WIDTH-1:0] data_q;
  logic             ready, accept, cnt_load, cnt_dec, is_one;

  assign cmd.cmd_ready = ready;
  assign accept        = cmd.cmd_valid & ready;

  step_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clock),
    .rst_n    (resetn),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cmd.cmd_count),
    .is_one   (is_one)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= ST_INIT;
    else         state <= state_nxt;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      op_q   <= OP_LOAD;
      data_q <= '0;
      result <= '0;
    end else begin
      if (accept) begin
        op_q   <= cmd.cmd_op;
        data_q <= cmd.cmd_data;
      end
      if (state == ST_DONE) result <= Q_fb;
    end
  end

  always_comb begin
    state_nxt     = state;
    ready         = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    reg_reset     = 1'b0;
    ParallelLoadn = 1'b0;
    RotateRight   = 1'b0;
    ASRight       = 1'b0;
    Data_IN       = Q_fb;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;
    case (state)
      ST_INIT: begin
        reg_reset = 1'b1;
        Data_IN   = '0;
        state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (cmd.cmd_valid) begin
          cnt_load = 1'b1;
          if (!is_shift(cmd.cmd_op))     state_nxt = ST_LOAD;
          else if (cmd.cmd_count == '0)  state_nxt = ST_DONE;
          else                           state_nxt = ST_SHIFT;
        end
      end
      ST_LOAD: begin
        Data_IN   = data_q;
        state_nxt = ST_DONE;
      end
      ST_SHIFT: begin
        ParallelLoadn = 1'b1;
        RotateRight   = (op_q != OP_ROTL);
        ASRight       = (op_q == OP_ASR);
        cnt_dec       = 1'b1;
        // Counter is at 1 on the last of the count shift cycles.
        if (is_one) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_INIT;
    endcase
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: behavioural 4-bit register on Q_fb, scoreboard of expected results.
module tb_shift_sequencer;
  import shift_seq_pkg::*;

  logic       clock = 1'b0;
  logic       resetn;
  logic [3:0] q_reg;
  logic       ParallelLoadn, RotateRight, ASRight, reg_reset, busy, done;
  logic [3:0] Data_IN, result;

  shift_sequencer_if #(.WIDTH(4), .CNT_W(3)) cmd_if ();

  shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .cmd           (cmd_if),
    .Q_fb          (q_reg),
    .ParallelLoadn (ParallelLoadn),
    .RotateRight   (RotateRight),
    .ASRight       (ASRight),
    .Data_IN       (Data_IN),
    .reg_reset     (reg_reset),
    .busy          (busy),
    .done          (done),
    .result        (result)
  );

  always #5 clock = ~clock;

  // The controlled register: sync reset, load when ParallelLoadn=0, otherwise shift.
  always @(posedge clock) begin
    if (reg_reset)           q_reg <= 4'b0000;
    else if (!ParallelLoadn) q_reg <= Data_IN;
    else if (!RotateRight)   q_reg <= {q_reg[2:0], q_reg[3]};
    else if (!ASRight)       q_reg <= {q_reg[0], q_reg[3:1]};
    else                     q_reg <= {q_reg[3], q_reg[3:1]};
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp_v, cyc);
    end
  endtask

  function automatic logic [3:0] ref_result(input op_e op, input logic [3:0] q,
                                            input logic [3:0] d, input int n);
    logic [3:0] r;
    r = q;
    if (op == OP_LOAD) return d;
    for (int i = 0; i < n; i++) begin
      case (op)
        OP_ROTL: r = {r[2:0], r[3]};
        OP_ROTR: r = {r[0], r[3:1]};
        default: r = {r[3], r[3:1]};
      endcase
    end
    return r;
  endfunction

  typedef struct {
    logic [3:0] res;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [3:0] exp_q = 4'b0000;
  logic [3:0] res_exp;
  logic       chk_res = 1'b0;
  int         acc_cnt = 0;
  int         lat;

  // Monitor: push on accept, pop and compare on done, check result the cycle after.
  always @(negedge clock) begin
    if (resetn === 1'b1) begin
      if (chk_res) begin
        chk("result", 32'(result), 32'(res_exp));
        chk_res = 1'b0;
      end
      if (done) begin
        if (sb.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
        else begin
          e = sb.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("q_at_done", 32'(q_reg), 32'(e.res));
          res_exp = e.res;
          chk_res = 1'b1;
        end
      end
      if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
        lat   = (cmd_if.cmd_op == OP_LOAD) ? 2 : int'(cmd_if.cmd_count) + 1;
        e.res = ref_result(cmd_if.cmd_op, exp_q, cmd_if.cmd_data, int'(cmd_if.cmd_count));
        e.cyc = cyc + lat;
        exp_q = e.res;
        sb.push_back(e);
        acc_cnt++;
      end
    end
  end

  task automatic flush();
    sb.delete();
    chk_res = 1'b0;
    exp_q   = 4'b0000;
  endtask

  task automatic release_reset();
    @(posedge clock); #1;
    resetn = 1'b1;
    @(negedge clock);
    chk("init_reg_reset", 32'(reg_reset), 32'd1);
    chk("init_ready", 32'(cmd_if.cmd_ready), 32'd0);
    chk("init_busy", 32'(busy), 32'd1);
    @(negedge clock);
    chk("idle_ready", 32'(cmd_if.cmd_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_q_zero", 32'(q_reg), 32'd0);
  endtask

  task automatic send(input op_e op, input logic [3:0] d, input logic [2:0] n);
    int t = 0;
    @(posedge clock); #1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = d;
    cmd_if.cmd_count = n;
    do begin
      @(negedge clock);
      t++;
    end while (!cmd_if.cmd_ready && t < 50);
    if (!cmd_if.cmd_ready) chk("accept_timeout", 32'(cmd_if.cmd_ready), 32'd1);
    @(posedge clock); #1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = op_e'(2'($urandom_range(0, 3)));
    cmd_if.cmd_data  = 4'($urandom);
    cmd_if.cmd_count = 3'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!(sb.size() == 0 && !chk_res && cmd_if.cmd_ready) && t < 60);
    if (t >= 60) chk("idle_timeout", 32'(cmd_if.cmd_ready), 32'd1);
  endtask

  task automatic run(input op_e op, input logic [3:0] d, input logic [2:0] n);
    send(op, d, n);
    wait_idle();
  endtask

  int a0;

  initial begin
    resetn           = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_LOAD;
    cmd_if.cmd_data  = 4'b0000;
    cmd_if.cmd_count = 3'd0;
    flush();
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_reg_reset", 32'(reg_reset), 32'd1);
    chk("rst_pln", 32'(ParallelLoadn), 32'd0);
    chk("rst_data_in", 32'(Data_IN), 32'd0);
    chk("rst_ready", 32'(cmd_if.cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_rot", 32'({RotateRight, ASRight}), 32'd0);
    release_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("hold_zero", 32'(q_reg), 32'd0);
    end

    run(OP_LOAD, 4'b1011, 3'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("hold_load", 32'(q_reg), 32'b1011);
    end

    run(OP_ROTR, 4'b0000, 3'd1);
    run(OP_LOAD, 4'b1011, 3'd0);
    run(OP_ROTL, 4'b0000, 3'd2);
    run(OP_LOAD, 4'b1000, 3'd0);
    run(OP_ASR,  4'b0000, 3'd3);
    run(OP_LOAD, 4'b0110, 3'd0);
    run(OP_ASR,  4'b0000, 3'd1);
    run(OP_ROTR, 4'b1111, 3'd0);
    run(OP_LOAD, 4'b0001, 3'd0);
    run(OP_ROTL, 4'b0000, 3'd7);

    // valid held across a whole command: second accept only in the first IDLE after DONE
    a0 = acc_cnt;
    @(posedge clock); #1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_LOAD;
    cmd_if.cmd_data  = 4'b0101;
    cmd_if.cmd_count = 3'd0;
    @(posedge clock);
    @(negedge clock);
    chk("busy_ready", 32'(cmd_if.cmd_ready), 32'd0);
    chk("busy_flag", 32'(busy), 32'd1);
    @(posedge clock);
    @(posedge clock); #1;
    chk("held_one_accept", 32'(acc_cnt - a0), 32'd1);
    @(posedge clock); #1;
    cmd_if.cmd_valid = 1'b0;
    chk("held_two_accepts", 32'(acc_cnt - a0), 32'd2);
    wait_idle();

    // reset asserted mid-SHIFT: abort, no done, register cleared
    run(OP_LOAD, 4'b1010, 3'd0);
    send(OP_ROTL, 4'b0000, 3'd5);
    @(posedge clock);
    @(negedge clock); #2;
    resetn = 1'b0;
    flush();
    #1;
    chk("abort_reg_reset", 32'(reg_reset), 32'd1);
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_ready", 32'(cmd_if.cmd_ready), 32'd0);
    chk("abort_pln", 32'(ParallelLoadn), 32'd0);
    @(posedge clock); #1;
    chk("abort_q_clear", 32'(q_reg), 32'd0);
    chk("abort_no_done", 32'(done), 32'd0);
    release_reset();
    run(OP_LOAD, 4'b0110, 3'd0);
    run(OP_ROTR, 4'b0000, 3'd2);

    for (int i = 0; i < 12; i++)
      run(op_e'(2'($urandom_range(0, 3))), 4'($urandom), 3'($urandom_range(0, 7)));

    repeat (3) @(negedge clock);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
